// File: rtl/gate_seq_pkg.sv
// Shared types and helpers for the gate vector sequencer.
// Holds the FSM state type, vector count and the gate reference model.
package gate_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NUM_VEC = 8;

  // Expected gate outputs packed as {t2, t1, t0}.
  function automatic logic [2:0] gate_expect(
    input logic a,
    input logic b,
    input logic c
  );
    return {~c, a | b, a & b};
  endfunction

endpackage

// File: rtl/gate_vector_seq.sv
// Sweeps all {a,b,c} vectors into a gate block and checks t0/t1/t2.
// Ports: clk, rst_n, start; a/b/c, vec_idx out; t0..t2 in; busy, mismatch, err_cnt, done, pass.
module gate_vector_seq
  import gate_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int ERR_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  input  logic             t0,
  input  logic             t1,
  input  logic             t2,
  output logic [2:0]       vec_idx,
  output logic             busy,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt,
  output logic             done,
  output logic             pass
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  localparam logic [2:0] LAST_VEC = 3'(NUM_VEC - 1);

  state_t           state;
  logic [HW-1:0]    hold_cnt;
  logic [2:0]       obs;
  logic [2:0]       exp_v;
  logic [2:0]       nxt_vec;
  logic             hit;
  logic [ERR_W-1:0] err_nxt;

  assign obs     = {t2, t1, t0};
  assign exp_v   = gate_expect(a, b, c);
  assign nxt_vec = vec_idx + 3'd1;

  assign busy = (state == DRIVE) || (state == SAMPLE);
  assign done = (state == DONE);

  // An unknown compare leaves hit set, so X counts as a miss.
  always_comb begin
    hit = 1'b1;
    if (obs == exp_v) hit = 1'b0;
    err_nxt = err_cnt;
    if (hit && (err_cnt != ERR_MAX)) err_nxt = err_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      vec_idx  <= '0;
      a        <= 1'b0;
      b        <= 1'b0;
      c        <= 1'b0;
      mismatch <= 1'b0;
      err_cnt  <= '0;
      pass     <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= DRIVE;
            vec_idx   <= '0;
            {a, b, c} <= 3'b000;
            hold_cnt  <= HOLD_LOAD;
            err_cnt   <= '0;
            pass      <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        DRIVE: begin
          if (hold_cnt == '0) state <= SAMPLE;
          else hold_cnt <= hold_cnt - 1'b1;
        end
        SAMPLE: begin
          mismatch <= hit;
          err_cnt  <= err_nxt;
          if (vec_idx == LAST_VEC) begin
            state <= DONE;
            pass  <= (err_nxt == '0);
          end else begin
            state     <= DRIVE;
            vec_idx   <= nxt_vec;
            {a, b, c} <= nxt_vec;
            hold_cnt  <= HOLD_LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_vector_seq.sv
// Self-checking bench for gate_vector_seq.
// Three instances cover HOLD_CYCLES=4/ERR_W=4, ERR_W=2 and HOLD_CYCLES=1.
module tb_gate_vector_seq;
  import gate_seq_pkg::*;

  logic clk;
  logic rst_n;
  logic [2:0] start;
  logic [2:0] f_t0z;
  logic [2:0] f_inv;

  logic [2:0][2:0] abc_o;
  logic [2:0][2:0] vec_o;
  logic [2:0][3:0] err_o;
  logic [2:0] busy_o;
  logic [2:0] mm_o;
  logic [2:0] done_o;
  logic [2:0] pass_o;

  int checks = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int HC = (g == 2) ? 1 : 4;
    localparam int EW = (g == 1) ? 2 : 4;
    logic a, b, c, t0, t1, t2;
    logic [2:0] vi;
    logic bz, mm, dn, ps;
    logic [EW-1:0] ec;
    logic [2:0] ex;

    assign ex = gate_expect(a, b, c);
    assign t0 = f_t0z[g] ? 1'b0 : (ex[0] ^ f_inv[g]);
    assign t1 = ex[1] ^ f_inv[g];
    assign t2 = ex[2] ^ f_inv[g];

    gate_vector_seq #(
      .HOLD_CYCLES(HC),
      .ERR_W(EW)
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start[g]),
      .a(a),
      .b(b),
      .c(c),
      .t0(t0),
      .t1(t1),
      .t2(t2),
      .vec_idx(vi),
      .busy(bz),
      .mismatch(mm),
      .err_cnt(ec),
      .done(dn),
      .pass(ps)
    );

    assign abc_o[g]  = {a, b, c};
    assign vec_o[g]  = vi;
    assign err_o[g]  = 4'(ec);
    assign busy_o[g] = bz;
    assign mm_o[g]   = mm;
    assign done_o[g] = dn;
    assign pass_o[g] = ps;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input int g, input string nm);
    chk({nm, "_busy"}, int'(busy_o[g]), 0);
    chk({nm, "_done"}, int'(done_o[g]), 0);
    chk({nm, "_mm"}, int'(mm_o[g]), 0);
    chk({nm, "_pass"}, int'(pass_o[g]), 0);
    chk({nm, "_err"}, int'(err_o[g]), 0);
    chk({nm, "_vec"}, int'(vec_o[g]), 0);
    chk({nm, "_abc"}, int'(abc_o[g]), 0);
  endtask

  // Start edge is cycle 0; cycle k is sampled on the negedge before edge k.
  task automatic run_sweep(
    input int g, input int hold, input int restart,
    input int exp_mm, input int exp_err, input bit exp_pass
  );
    int total;
    int mmc;
    int ev;
    total = 8 * (hold + 1) + 1;
    mmc = 0;
    @(negedge clk);
    start[g] = 1'b1;
    for (int k = 1; k <= total + 1; k++) begin
      @(negedge clk);
      start[g] = (k == restart);
      ev = (k < total) ? (k - 1) / (hold + 1) : 7;
      chk($sformatf("busy_g%0d_c%0d", g, k), int'(busy_o[g]), int'(k < total));
      chk($sformatf("done_g%0d_c%0d", g, k), int'(done_o[g]), int'(k == total));
      chk($sformatf("vec_g%0d_c%0d", g, k), int'(vec_o[g]), ev);
      chk($sformatf("abc_g%0d_c%0d", g, k), int'(abc_o[g]), ev);
      mmc += int'(mm_o[g]);
      if (k == 1) begin
        chk($sformatf("err_clr_g%0d", g), int'(err_o[g]), 0);
        chk($sformatf("pass_clr_g%0d", g), int'(pass_o[g]), 0);
      end
      if (k == total) begin
        chk($sformatf("err_done_g%0d", g), int'(err_o[g]), exp_err);
        chk($sformatf("pass_done_g%0d", g), int'(pass_o[g]), int'(exp_pass));
        chk($sformatf("mm_at_done_g%0d", g), int'(mm_o[g]), int'(exp_mm > 0));
      end
      if (k == total + 1) begin
        chk($sformatf("pass_hold_g%0d", g), int'(pass_o[g]), int'(exp_pass));
        chk($sformatf("err_hold_g%0d", g), int'(err_o[g]), exp_err);
      end
    end
    chk($sformatf("mm_count_g%0d", g), mmc, exp_mm);
    start[g] = 1'b0;
  endtask

  typedef struct {
    int g;
    int hold;
    bit t0z;
    bit inv;
    int restart;
    int exp_mm;
    int exp_err;
    bit exp_pass;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{g: 0, hold: 4, t0z: 0, inv: 0, restart: 0,
               exp_mm: 0, exp_err: 0, exp_pass: 1};
    tbl[1] = '{g: 0, hold: 4, t0z: 1, inv: 0, restart: 0,
               exp_mm: 2, exp_err: 2, exp_pass: 0};
    tbl[2] = '{g: 0, hold: 4, t0z: 0, inv: 0, restart: 10,
               exp_mm: 0, exp_err: 0, exp_pass: 1};
    tbl[3] = '{g: 1, hold: 4, t0z: 0, inv: 1, restart: 0,
               exp_mm: 8, exp_err: 3, exp_pass: 0};
    tbl[4] = '{g: 2, hold: 1, t0z: 0, inv: 0, restart: 0,
               exp_mm: 0, exp_err: 0, exp_pass: 1};

    rst_n = 1'b0;
    start = '0;
    f_t0z = '0;
    f_inv = '0;
    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) chk_zero(g, $sformatf("rst_g%0d", g));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) chk_zero(g, $sformatf("idle_g%0d", g));

    for (int i = 0; i < 5; i++) begin
      f_t0z[tbl[i].g] = tbl[i].t0z;
      f_inv[tbl[i].g] = tbl[i].inv;
      run_sweep(tbl[i].g, tbl[i].hold, tbl[i].restart,
                tbl[i].exp_mm, tbl[i].exp_err, tbl[i].exp_pass);
      f_t0z = '0;
      f_inv = '0;
      repeat (2) @(negedge clk);
    end

    // Saturation onset on ERR_W=2: err 2 in vector 2 drive, 3 after.
    f_inv[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      start[1] = 1'b0;
      if (k == 12) chk("sat_pre", int'(err_o[1]), 2);
      if (k == 16) chk("sat_at3", int'(err_o[1]), 3);
    end
    f_inv[1] = 1'b0;
    repeat (40) @(negedge clk);

    // Async reset mid-sweep while vector 3 is driven.
    f_inv[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      start[0] = 1'b0;
    end
    chk("pre_rst_vec", int'(vec_o[0]), 3);
    chk("pre_rst_err", int'(err_o[0]), 3);
    chk("pre_rst_busy", int'(busy_o[0]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero(0, "async_rst");
    f_inv[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_no_done", int'(done_o[0]), 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero(0, "post_rst");
    run_sweep(0, 4, 0, 0, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
